// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types: block geometry, coefficient width, zigzag LUT and sideband struct.
// Zigzag LUT maps scan position (8*beat + lane) to natural index (8*row + column).
package jpeg_pkg;

  localparam int BLK_N  = 8;
  localparam int COEF_W = 16;
  localparam int IDX_W  = $clog2(BLK_N);
  localparam int ADDR_W = 2 * IDX_W;

  localparam int ZZ_LUT [BLK_N*BLK_N] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct packed {
    logic sob;
    logic eob;
    logic sof;
  } sb_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/zz_bank.sv
// 8x8 coefficient bank: row write port, combinational 8-lane zigzag read port addressed by beat.
// Latency: write visible the cycle after the edge; no reset on contents; no backpressure.
module zz_bank
  import jpeg_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_row,
  input  logic [BLK_N-1:0][W-1:0]   wr_data,
  input  logic [IDX_W-1:0]          rd_beat,
  output logic [BLK_N-1:0][W-1:0]   rd_data
);

  logic [BLK_N-1:0][W-1:0] mem [BLK_N];
  logic [ADDR_W-1:0]       nat;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Each lane looks up its natural position, then splits it into row/column.
  always_comb begin
    nat     = '0;
    rd_data = '0;
    for (int j = 0; j < BLK_N; j++) begin
      nat        = ADDR_W'(ZZ_LUT[{rd_beat, IDX_W'(j)}]);
      rd_data[j] = mem[nat[ADDR_W-1:IDX_W]][nat[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/zigzag_buf.sv
// Ping-pong 8x8 zigzag reorder buffer; define ZIGZAG_PROTO_CHECK_EN to drive proto_err.
// Latency: beat 0 registered one edge after row 7; 8 gapless beats; no backpressure on either side.
module zigzag_buf
  import jpeg_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [BLK_N-1:0][W-1:0]   in_data,
  input  logic                      in_sob,
  input  logic                      in_eob,
  input  logic                      in_sof,
  output logic                      out_valid,
  output logic [BLK_N-1:0][W-1:0]   out_data,
  output logic                      out_sob,
  output logic                      out_eob,
  output logic                      out_sof,
  output logic                      proto_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLK_N - 1);

  wr_state_t               wr_state, wr_state_nxt;
  logic [IDX_W-1:0]        wr_row, wr_row_nxt, wr_addr;
  logic                    wr_en, wr_done;
  logic                    wr_bank, wr_sof;
  logic                    rd_bank, rd_sof, rd_active;
  logic [IDX_W-1:0]        rd_beat;
  logic [BLK_N-1:0][W-1:0] bank_rd [2];
  logic [BLK_N-1:0][W-1:0] rd_data;
  sb_t                     out_sb;

  // A sob always restarts the write bank at row 0, discarding any partial block.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_row_nxt   = wr_row;
    wr_addr      = wr_row;
    wr_en        = 1'b0;
    wr_done      = 1'b0;
    if (in_valid) begin
      if (in_sob) begin
        wr_en        = 1'b1;
        wr_addr      = '0;
        wr_state_nxt = WR_FILL;
        wr_row_nxt   = IDX_W'(1);
      end else if (wr_state == WR_FILL) begin
        wr_en = 1'b1;
        if (wr_row == LAST) begin
          wr_done      = 1'b1;
          wr_state_nxt = WR_IDLE;
          wr_row_nxt   = '0;
        end else begin
          wr_row_nxt = wr_row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      wr_row    <= '0;
      wr_bank   <= 1'b0;
      wr_sof    <= 1'b0;
      rd_bank   <= 1'b0;
      rd_sof    <= 1'b0;
      rd_active <= 1'b0;
      rd_beat   <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_row   <= wr_row_nxt;
      if (in_valid && in_sob) begin
        wr_sof <= in_sof;
      end
      // A completing block takes over the read side even on the last drain beat.
      if (wr_done) begin
        wr_bank   <= ~wr_bank;
        rd_bank   <= wr_bank;
        rd_sof    <= wr_sof;
        rd_active <= 1'b1;
        rd_beat   <= '0;
      end else if (rd_active) begin
        rd_beat <= rd_beat + 1'b1;
        if (rd_beat == LAST) begin
          rd_active <= 1'b0;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank #(.W(W)) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && !rst && (wr_bank == 1'(b))),
      .wr_row  (wr_addr),
      .wr_data (in_data),
      .rd_beat (rd_beat),
      .rd_data (bank_rd[b])
    );
  end

  assign rd_data = bank_rd[rd_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sb    <= '0;
    end else begin
      out_valid  <= rd_active;
      out_sb.sob <= rd_active && (rd_beat == '0);
      out_sb.eob <= rd_active && (rd_beat == LAST);
      out_sb.sof <= rd_active && (rd_beat == '0) && rd_sof;
      if (rd_active) begin
        out_data <= rd_data;
      end
    end
  end

  assign out_sob = out_sb.sob;
  assign out_eob = out_sb.eob;
  assign out_sof = out_sb.sof;

`ifdef ZIGZAG_PROTO_CHECK_EN
  logic err_nxt;

  always_comb begin
    err_nxt = in_valid && ((in_eob != wr_done) ||
                           (in_sob && (wr_state == WR_FILL)) ||
                           (!in_sob && (wr_state == WR_IDLE)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else begin
      proto_err <= err_nxt;
    end
  end
`else
  logic unused_eob;
  assign unused_eob = in_eob;
  assign proto_err  = 1'b0;
`endif

endmodule
